// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and the prefetch slot payload type.
package riscv_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } slot_t;
endpackage

// File: rtl/prefetch_slot_ram.sv
// Prefetch slot storage: reserve writes the PC, fill writes the instruction, filled bits track arrival.
module prefetch_slot_ram
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_idx,
    input  logic [XLEN-1:0] rsv_pc,
    input  logic            fill_en,
    input  logic [AW-1:0]   fill_idx,
    input  logic [ILEN-1:0] fill_instr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_idx,
    input  logic            flush,
    input  logic [AW-1:0]   rd_idx,
    output slot_t           rd_slot,
    output logic            rd_filled
);
    slot_t            mem [DEPTH];
    logic [DEPTH-1:0] filled;

    // Payload needs no reset; only the filled bits qualify it.
    always_ff @(posedge clk) begin
        if (rsv_en)  mem[rsv_idx].pc     <= rsv_pc;
        if (fill_en) mem[fill_idx].instr <= fill_instr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filled <= '0;
        end else if (flush) begin
            filled <= '0;
        end else begin
            if (fill_en) filled[fill_idx] <= 1'b1;
            if (clr_en)  filled[clr_idx]  <= 1'b0;
        end
    end

    assign rd_slot   = mem[rd_idx];
    assign rd_filled = filled[rd_idx];
endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction-fetch prefetch buffer: issues sequential fetches, buffers in-order responses,
// presents the head to IF/ID, and flushes on taken-branch redirect.
module fetch_prefetch_buffer
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            if_valid,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [AW-1:0]   wr_ptr, fill_ptr, rd_ptr;
    logic [CW-1:0]   count, pend, drop_cnt;
    logic [CW:0]     credit;
    logic            accept, pop, fill, drop, rsp_owned, head_filled;
    slot_t           head;

    // Stale responses still in flight hold credit until they drain.
    assign credit         = {1'b0, count} + {1'b0, drop_cnt};
    assign imem_req_valid = !reset && !redirect_valid && (credit < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign if_valid = (count != '0) && head_filled;
    assign if_instr = if_valid ? head.instr : NOP_INSTR;
    assign if_pc    = if_valid ? head.pc : '0;
    assign pop      = if_valid && !stall && !redirect_valid;

    assign drop      = imem_rsp_valid && (drop_cnt != '0);
    assign fill      = imem_rsp_valid && (drop_cnt == '0) && (pend != '0) && !redirect_valid;
    assign rsp_owned = imem_rsp_valid && ((drop_cnt != '0) || (pend != '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            // A response landing now belongs to an outstanding fetch and is consumed here.
            fetch_pc <= redirect_pc & ~XLEN'(3);
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= drop_cnt + pend - CW'(rsp_owned);
        end else begin
            if (accept) begin
                wr_ptr   <= wr_ptr + AW'(1);
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (fill) fill_ptr <= fill_ptr + AW'(1);
            if (pop)  rd_ptr   <= rd_ptr + AW'(1);
            if (drop) drop_cnt <= drop_cnt - CW'(1);
            count <= count + CW'(accept) - CW'(pop);
            pend  <= pend + CW'(accept) - CW'(fill);
        end
    end

    prefetch_slot_ram #(.DEPTH(DEPTH), .AW(AW)) u_slots (
        .clk        (clk),
        .reset      (reset),
        .rsv_en     (accept),
        .rsv_idx    (wr_ptr),
        .rsv_pc     (fetch_pc),
        .fill_en    (fill),
        .fill_idx   (fill_ptr),
        .fill_instr (imem_rsp_instr),
        .clr_en     (pop),
        .clr_idx    (rd_ptr),
        .flush      (redirect_valid),
        .rd_idx     (rd_ptr),
        .rd_slot    (head),
        .rd_filled  (head_filled)
    );
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: in-order memory with configurable latency, a queue-level
// model of the fetch stream, per-cycle output comparison and directed literal checks.
module tb_fetch_prefetch_buffer;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_instr = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;

    fetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_instr(imem_rsp_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; int seq; bit filled; } ent_t;
    typedef struct { logic [63:0] addr; int seq; int due; bit stale; } mem_t;

    ent_t        q[$];    // fetches the front end owes decode, in program order
    mem_t        mq[$];   // requests the memory still has to answer
    logic [63:0] exp_pc;
    int          seq_n, cyc, last_due;
    int          total = 0, bad = 0;

    // stimulus knobs
    bit          rst_v = 1'b1, rdy = 1'b0, stl = 1'b0, rd = 1'b0;
    logic [63:0] rpc = '0;
    int          lat = 1;

    function automatic logic [31:0] instr_of(logic [63:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    // One cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic step();
        mem_t        m;
        ent_t        e;
        int          nstale;
        bit          go, e_req, e_iv;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        @(negedge clk);
        reset          = rst_v;
        imem_req_ready = rdy;
        stall          = stl;
        redirect_valid = rd;
        redirect_pc    = rpc;
        go = !rst_v && mq.size() > 0 && mq[0].due <= cyc;
        imem_rsp_valid = go;
        imem_rsp_instr = go ? instr_of(mq[0].addr) : 32'hDEAD_BEEF;
        #1;
        if (rst_v) begin
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_if_valid", if_valid, 0);
            chk("rst_if_instr", if_instr, NOP);
            chk("rst_if_pc", if_pc, 0);
            q.delete();
            mq.delete();
            exp_pc = 64'h0; seq_n = 0; cyc = 0; last_due = -1;
            return;
        end
        nstale = 0;
        foreach (mq[i]) if (mq[i].stale) nstale++;
        e_req = !rd && (q.size() + nstale < DEPTH);
        e_iv  = q.size() > 0 && q[0].filled;
        e_pc  = 64'h0;
        e_ins = NOP;
        if (e_iv) begin
            e_pc  = q[0].pc;
            e_ins = instr_of(q[0].pc);
        end
        chk("req_valid", imem_req_valid, e_req);
        if (e_req) chk("req_addr", imem_req_addr, exp_pc);
        chk("if_valid", if_valid, e_iv);
        chk("if_pc", if_pc, e_pc);
        chk("if_instr", if_instr, e_ins);

        if (go) begin
            m = mq.pop_front();
            if (!rd && !m.stale)
                foreach (q[i]) if (q[i].seq == m.seq) q[i].filled = 1'b1;
        end
        if (rd) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            q.delete();
            exp_pc = rpc & ~64'h3;
        end else begin
            if (e_iv && !stl) e = q.pop_front();
            if (e_req && rdy) begin
                e.pc = exp_pc; e.seq = seq_n; e.filled = 1'b0;
                q.push_back(e);
                m.addr = exp_pc; m.seq = seq_n; m.stale = 1'b0;
                m.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = m.due;
                mq.push_back(m);
                exp_pc += 64'h4;
                seq_n++;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_v = 1'b1; rd = 1'b0;
        step(); step();
        rst_v = 1'b0;
    endtask

    initial begin
        int nreq, npop;
        logic [63:0] nxt;

        // 1: free-running, 1-cycle memory
        lat = 1; rdy = 1; stl = 0;
        do_reset();
        step(); chk("t1_addr0", imem_req_addr, 64'h0); chk("t1_iv_c0", if_valid, 0);
        step(); chk("t1_addr1", imem_req_addr, 64'h4); chk("t1_iv_c1", if_valid, 0);
        step(); chk("t1_iv_c2", if_valid, 1); chk("t1_pc_c2", if_pc, 64'h0);
                chk("t1_addr2", imem_req_addr, 64'h8);
        step(); chk("t1_pc_c3", if_pc, 64'h4);
        repeat (8) step();

        // 2: stall fills the buffer, then drains in order
        stl = 1;
        do_reset();
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (imem_req_valid && rdy) nreq++;
        end
        chk("t2_nreq", nreq, 4);
        chk("t2_full_noreq", imem_req_valid, 0);
        chk("t2_hold_pc", if_pc, 64'h0);
        stl = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_drain_pc", if_pc, 64'(4 * k));
        end
        repeat (4) step();

        // 3: redirect with three fetches outstanding at latency 3
        lat = 3; stl = 0;
        do_reset();
        repeat (3) step();
        rd = 1; rpc = 64'h103;
        step(); chk("t3_noreq_redir", imem_req_valid, 0);
        rd = 0;
        step(); chk("t3_req_after", imem_req_valid, 1); chk("t3_addr", imem_req_addr, 64'h100);
        repeat (3) step();
        chk("t3_iv_c7", if_valid, 0);
        step();
        chk("t3_iv_c8", if_valid, 1); chk("t3_pc", if_pc, 64'h100);
        chk("t3_instr", if_instr, 32'hA500_0100);
        repeat (6) step();

        // 4: redirect with stall, a response landing in the same cycle
        lat = 1; stl = 1;
        do_reset();
        repeat (3) step();
        rd = 1; rpc = 64'h200;
        step(); chk("t4_head_shown", if_valid, 1); chk("t4_noreq", imem_req_valid, 0);
        rd = 0;
        step(); chk("t4_iv_after", if_valid, 0); chk("t4_nop", if_instr, NOP);
        chk("t4_addr", imem_req_addr, 64'h200);

        // 5: reset with two slots filled
        repeat (3) step();
        chk("t5_pre_pc", if_pc, 64'h200);
        rst_v = 1;
        step(); chk("t5_iv", if_valid, 0); chk("t5_instr", if_instr, NOP);
        rst_v = 0; stl = 0;
        step(); chk("t5_addr", imem_req_addr, 64'h0); chk("t5_req", imem_req_valid, 1);

        // 6: random ready and stall, 64 instructions strictly sequential
        lat = 2;
        do_reset();
        npop = 0; nxt = 64'h0;
        for (int i = 0; i < 3000 && npop < 64; i++) begin
            rdy = ($urandom_range(0, 1) == 1);
            stl = ($urandom_range(0, 3) == 0);
            step();
            if (if_valid && !stl) begin
                chk("t6_seq_pc", if_pc, nxt);
                nxt += 64'h4;
                npop++;
            end
        end
        chk("t6_count", npop, 64);

        // 7: fetch address wraps past the top of the address space
        rdy = 0; stl = 0;
        repeat (4) step();
        rd = 1; rpc = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        rd = 0; rdy = 1;
        step(); chk("t7_addr_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step(); chk("t7_addr_wrap", imem_req_addr, 64'h0);
        repeat (8) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
